// File: rtl/buffer_reg.sv
// Parallel-in/parallel-out buffer register with a configurable number of
// retiming stages; q is taken straight from the last stage.
module buffer_reg #(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Synchronous clear has priority over capture; otherwise shift one stage per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RST_VAL;
            end
        end else begin
            stage[0] <= x;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: tb/tb_buffer_reg.sv
// Directed bench for buffer_reg: default 4-bit single-stage build and an
// 8-bit, 3-stage build with a non-zero reset value.
module tb_buffer_reg;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [3:0] x_a;
    logic [3:0] q_a;
    logic       rst_b;
    logic [7:0] x_b;
    logic [7:0] q_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_reg dut_a (
        .clk (clk),
        .rst (rst_a),
        .x   (x_a),
        .q   (q_a)
    );

    buffer_reg #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'hA5)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .x   (x_b),
        .q   (q_b)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge, mid-cycle.
    initial begin
        rst_a = 1'b0;
        x_a   = 4'b1010;
        rst_b = 1'b0;
        x_b   = 8'h00;

        // Reset held for two edges while x = 1010
        @(negedge clk);
        check_eq("reset_edge1", 8'(q_a), 8'h00);
        @(negedge clk);
        check_eq("reset_edge2", 8'(q_a), 8'h00);

        // Sweep 0..15 with a one-edge reset at x = 9
        rst_a = 1'b1;
        for (int v = 0; v < 16; v++) begin
            x_a = 4'(v);
            if (v == 9) begin
                rst_a = 1'b0;
                @(negedge clk);
                check_eq("midstream_reset", 8'(q_a), 8'h00);
                rst_a = 1'b1;
            end
            @(negedge clk);
            check_eq($sformatf("sweep_%0d", v), 8'(q_a), 8'(v));
        end

        // Hold: x toggles between edges, q must not follow
        x_a = 4'b0110;
        @(negedge clk);
        check_eq("hold_latch", 8'(q_a), 8'h06);
        #1 x_a = 4'b1001;
        #1 x_a = 4'b0011;
        #1;
        check_eq("hold_between_edges", 8'(q_a), 8'h06);
        @(negedge clk);
        check_eq("hold_next_edge", 8'(q_a), 8'h03);

        // Reset pulse strictly between edges is ignored
        x_a = 4'b0011;
        #1 rst_a = 1'b0;
        #2 rst_a = 1'b1;
        check_eq("async_pulse_now", 8'(q_a), 8'h03);
        @(negedge clk);
        check_eq("async_pulse_edge", 8'(q_a), 8'h03);

        // Three-stage build: rst_b has been low for many edges
        check_eq("b_reset", q_b, 8'hA5);
        rst_b = 1'b1;
        x_b   = 8'h3C;
        @(negedge clk);
        x_b = 8'h11;
        check_eq("b_fill_n", q_b, 8'hA5);
        @(negedge clk);
        x_b = 8'h22;
        check_eq("b_fill_n1", q_b, 8'hA5);
        @(negedge clk);
        check_eq("b_out_3c", q_b, 8'h3C);
        @(negedge clk);
        check_eq("b_out_11", q_b, 8'h11);

        // Mid-stream reset on the pipeline discards in-flight data
        rst_b = 1'b0;
        x_b   = 8'h77;
        @(negedge clk);
        check_eq("b_midreset", q_b, 8'hA5);
        rst_b = 1'b1;
        x_b   = 8'h5A;
        @(negedge clk);
        x_b = 8'h6B;
        check_eq("b_drain1", q_b, 8'hA5);
        @(negedge clk);
        check_eq("b_drain2", q_b, 8'hA5);
        @(negedge clk);
        check_eq("b_resume", q_b, 8'h5A);
        @(negedge clk);
        check_eq("b_resume2", q_b, 8'h6B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_reg.md
# buffer_reg

Parallel-in/parallel-out buffer register: captures a multi-bit data word on every rising clock edge and presents it on its output until the next edge. Used as a generic staging/retiming element between combinational logic and downstream consumers. Optional extra pipeline stages give a fixed multi-cycle delay line. There is no enable and no handshake.

## Interface

Parameters:
- WIDTH, 4: data width in bits for x and q; legal range ≥ 1.
- STAGES, 1: number of register stages between x and q; legal range ≥ 1.
- RST_VAL, {WIDTH{1'b0}}: value loaded into every stage on reset.

Ports, in positional order clk, rst, x, q:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- x  input  WIDTH  data word to be buffered.
- q  output  WIDTH  buffered data; driven directly from the last register stage.

## Operation

- State: STAGES registers, each WIDTH bits: stage[0] … stage[STAGES-1].
- Each rising edge of clk:
  - rst = 0: every stage <= RST_VAL. x is ignored.
  - rst = 1: stage[0] <= x and stage[k] <= stage[k-1] for k = 1 … STAGES-1.
- q = stage[STAGES-1], with no combinational path from x to q.
- No arithmetic. Data passes bit-exact and all WIDTH bits are treated identically.
- X/Z on x propagates unchanged. No filtering.

## Timing

- Reset is synchronous: rst is only sampled at rising edges. Asserting it between edges has no effect until the next edge.
- Reset value: q = RST_VAL (default 4'b0000) from the first edge at which rst = 0 is sampled.
- Before the first clock edge, q is undefined. The bench must apply reset before checking values.
- Latency: a value on x that is stable at rising edge N appears on q after edge N + STAGES - 1, i.e. 1 cycle for the default configuration.
- Throughput: one new word per cycle. Back-to-back changing inputs are each captured.
- Hold: q holds its value between edges regardless of x activity.
- Reset release: on the first edge with rst = 1, stage[0] captures x. In multi-stage configurations, RST_VAL drains out of the downstream stages over the following STAGES-1 cycles.
- Reset mid-stream: a single edge with rst = 0 clears all stages to RST_VAL. In-flight data is discarded, and nothing captured before reset reappears on q.
- Simultaneous change of x and rst near an edge: reset has priority.

## Test plan

- Reset: hold rst = 0 for 2 edges with x = 4'b1010 -> q = 4'b0000 after the first sampled edge, and it stays 0000.
- Sweep: release rst and drive x = 0 … 15, one value per 10-unit clock period (x changes mid-low phase) -> q equals each x one edge later, 0000 through 1111 in order, with no skips.
- Hold: set x = 4'b0110, latch it, then toggle x between clock edges only -> q stays 0110 until the next rising edge.
- Mid-stream reset: while the sweep is at x = 4'b1001, drive rst = 0 for one edge -> q = 0000 on that edge. After release, q resumes with the current x one edge later.
- Asynchronous-reset rejection: pulse rst = 0 strictly between two edges -> q unchanged.
- Parameterised build with WIDTH = 8, STAGES = 3, RST_VAL = 8'hA5:
  - After reset, q = A5.
  - Drive 8'h3C at edge N -> q = 3C after edge N + 2, and q = A5 until the pipeline fills.
